frame_fetch: RTL and testbench



---
 rtl/frame_fetch_pkg.sv | 21 ++
 rtl/frame_fetch_pixel_fifo.sv | 83 ++++++++
 rtl/frame_fetch.sv | 117 +++++++++++
 tb/tb_frame_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_fetch_pkg.sv
// Shared types and defaults for the RP2040 framebuffer prefetch stage.
// Counter widths leave room for a value equal to the FIFO depth.
package frame_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESET_FB = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    localparam int DEF_PIXEL_BITS   = 4;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_REQ_LATENCY  = 2;
    localparam int DEF_RESET_CYCLES = 4;

    // Width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/frame_fetch_pixel_fifo.sv
// Pixel buffer with a registered head: write-to-valid 1 cycle, pop advances head next cycle.
// Pop while empty is ignored; a write into a full buffer is dropped unless a pop frees a slot.
module pixel_fifo
    import frame_fetch_pkg::*;
#(
    parameter int WIDTH = DEF_PIXEL_BITS,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic                        i_wr,
    input  logic [WIDTH-1:0]            i_wr_dat,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_head_dat,
    output logic                        o_vld,
    output logic [cnt_width(DEPTH)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop_ok;
    logic             w_wr_ok;
    logic [AW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_pop_ok    = i_pop && (r_count != '0);
    assign w_wr_ok     = i_wr && ((r_count != CW'(DEPTH)) || w_pop_ok);
    assign w_rd_nxt    = r_rd_ptr + AW'(w_pop_ok);
    assign w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_pop_ok);

    // The incoming word becomes the head when nothing older survives this cycle.
    always_comb begin
        w_head_nxt = '0;
        if (w_count_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_wr_ok && (r_count == CW'(w_pop_ok))) begin
            w_head_nxt = i_wr_dat;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    assign o_head_dat = r_head;
    assign o_vld      = (r_count != '0);
    assign o_count    = r_count;

endmodule

// File: rtl/frame_fetch.sv
// Credit-limited request engine to the RP2040 framebuffer; samples REQ_LATENCY cycles after each strobe.
// Requests stall while buffered + outstanding pixels fill the FIFO; frame_start flushes everything.
module frame_fetch
    import frame_fetch_pkg::*;
#(
    parameter int PIXEL_BITS   = DEF_PIXEL_BITS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int REQ_LATENCY  = DEF_REQ_LATENCY,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  pixel_pop,
    output logic [PIXEL_BITS-1:0] pixel_out,
    output logic                  pixel_valid,
    output logic                  underflow,
    output logic                  frame_next_pixel_out,
    output logic                  frame_reset_out,
    input  logic [PIXEL_BITS-1:0] frame_pixel_in
);

    localparam int CW  = cnt_width(FIFO_DEPTH);
    localparam int RCW = $clog2(RESET_CYCLES + 1);

    state_t                 r_state;
    logic [RCW-1:0]         r_rst_cnt;
    logic                   r_strobe;
    logic                   r_reset_out;
    logic                   r_underflow;
    logic [REQ_LATENCY-1:0] r_tag;
    logic [CW-1:0]          r_in_flight;

    logic [CW-1:0]          w_occ;
    logic                   w_capture;
    logic                   w_credit;
    logic                   w_stream_next;
    logic                   w_issue;

    assign w_capture = r_tag[REQ_LATENCY-1];
    assign w_credit  = (({1'b0, w_occ} + {1'b0, r_in_flight}) < (CW+1)'(FIFO_DEPTH));

    // Strobe is registered, so the decision looks at the state we are about to be in.
    assign w_stream_next = (r_state == ST_STREAM) ||
                           ((r_state == ST_RESET_FB) && (r_rst_cnt == '0));
    assign w_issue       = w_stream_next && !r_strobe && w_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rst_cnt   <= '0;
            r_strobe    <= 1'b0;
            r_reset_out <= 1'b0;
            r_underflow <= 1'b0;
            r_tag       <= '0;
            r_in_flight <= '0;
        end else if (frame_start) begin
            r_state     <= ST_RESET_FB;
            r_rst_cnt   <= RCW'(RESET_CYCLES - 1);
            r_strobe    <= 1'b0;
            r_reset_out <= 1'b1;
            r_underflow <= 1'b0;
            r_tag       <= '0;
            r_in_flight <= '0;
        end else begin
            r_strobe    <= w_issue;
            r_tag[0]    <= r_strobe;
            for (int i = 1; i < REQ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_in_flight <= r_in_flight + CW'(w_issue) - CW'(w_capture);
            if (pixel_pop && !pixel_valid) begin
                r_underflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_reset_out <= 1'b0;
                end
                ST_RESET_FB: begin
                    if (r_rst_cnt == '0) begin
                        r_state     <= ST_STREAM;
                        r_reset_out <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 1'b1;
                    end
                end
                ST_STREAM: begin
                    r_reset_out <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_reset_out <= 1'b0;
                end
            endcase
        end
    end

    pixel_fifo #(
        .WIDTH (PIXEL_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (frame_start),
        .i_wr       (w_capture),
        .i_wr_dat   (frame_pixel_in),
        .i_pop      (pixel_pop),
        .o_head_dat (pixel_out),
        .o_vld      (pixel_valid),
        .o_count    (w_occ)
    );

    assign underflow            = r_underflow;
    assign frame_next_pixel_out = r_strobe;
    assign frame_reset_out      = r_reset_out;

endmodule

// File: tb/tb_frame_fetch.sv
// Directed bench for frame_fetch with a small RP2040 responder answering strobes two cycles later.
module tb_frame_fetch;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       pixel_pop;
    logic [3:0] pixel_out;
    logic       pixel_valid;
    logic       underflow;
    logic       frame_next_pixel_out;
    logic       frame_reset_out;
    logic [3:0] frame_pixel_in;

    int n_tests = 0;
    int n_fail  = 0;

    frame_fetch dut (
        .clk                  (clk),
        .rst                  (rst),
        .frame_start          (frame_start),
        .pixel_pop            (pixel_pop),
        .pixel_out            (pixel_out),
        .pixel_valid          (pixel_valid),
        .underflow            (underflow),
        .frame_next_pixel_out (frame_next_pixel_out),
        .frame_reset_out      (frame_reset_out),
        .frame_pixel_in       (frame_pixel_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response n of a frame: 3, 7, A, F, then n mod 16.
    function automatic logic [3:0] pix_of(input int n);
        case (n)
            0:       return 4'h3;
            1:       return 4'h7;
            2:       return 4'hA;
            3:       return 4'hF;
            default: return 4'(n);
        endcase
    endfunction

    // RP2040 model: the pixel for a strobe seen in cycle c is on the bus during cycle c+2.
    logic [2:0] hist;
    int         midx;
    always @(negedge clk) begin
        if (rst) begin
            hist           = 3'b000;
            midx           = 0;
            frame_pixel_in = 4'h5;
        end else begin
            hist = {hist[1:0], frame_next_pixel_out};
            if (hist[2]) begin
                frame_pixel_in = pix_of(midx);
                midx++;
            end else begin
                frame_pixel_in = 4'h5;
            end
            if (frame_reset_out) midx = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse frame_start and log 16 following cycles (bit i = cycle i after the pulse).
    task automatic record_frame(output logic [15:0] rm, output logic [15:0] sm,
                                output logic [15:0] vm, output logic uf0, output logic [3:0] occ0);
        frame_start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin
                frame_start = 1'b0;
                uf0  = underflow;
                occ0 = 4'(dut.w_occ);
            end
            rm[i] = frame_reset_out;
            sm[i] = frame_next_pixel_out;
            vm[i] = pixel_valid;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rm, sm, vm;
        logic        uf0;
        logic [3:0]  occ0;
        int          cnt_stb, cnt_vld, cnt_rst, w;

        rst = 1'b1; frame_start = 1'b0; pixel_pop = 1'b0;
        tick(); tick();
        check("rst_pixel_out", pixel_out, 0);
        check("rst_valid", pixel_valid, 0);
        check("rst_underflow", underflow, 0);
        check("rst_strobe", frame_next_pixel_out, 0);
        check("rst_reset_out", frame_reset_out, 0);
        rst = 1'b0;

        // Idle with no frame_start.
        cnt_stb = 0; cnt_vld = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt_stb += int'(frame_next_pixel_out);
            cnt_vld += int'(pixel_valid);
        end
        check("idle_strobes", cnt_stb, 0);
        check("idle_valid", cnt_vld, 0);

        // First frame: reset pulse of 4, strobes every other cycle until credits run out.
        record_frame(rm, sm, vm, uf0, occ0);
        check("f1_reset_mask", rm, 16'h000F);
        check("f1_strobe_mask", sm, 16'h0550);
        check("f1_valid_mask", vm, 16'hFF80);
        check("f1_head", pixel_out, 4'h3);
        check("f1_occ_full", dut.w_occ, 4);
        check("f1_inflight", dut.r_in_flight, 0);

        // Blind pop every second cycle across pointer wrap.
        for (int n = 0; n < 20; n++) begin
            check($sformatf("stream_vld_%0d", n), pixel_valid, 1);
            check($sformatf("stream_pix_%0d", n), pixel_out, pix_of(n));
            pixel_pop = 1'b1;
            tick();
            pixel_pop = 1'b0;
            tick();
            check($sformatf("stream_occ_le_depth_%0d", n), 32'(dut.w_occ <= 4), 1);
        end
        check("stream_underflow", underflow, 0);

        // Pop right after the reset phase while empty.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("f2_reset_out", frame_reset_out, 1);
        check("f2_flushed", pixel_valid, 0);
        tick(); tick(); tick(); tick();
        check("f2_first_strobe", frame_next_pixel_out, 1);
        check("f2_empty", pixel_valid, 0);
        pixel_pop = 1'b1;
        tick();
        pixel_pop = 1'b0;
        check("f2_underflow_set", underflow, 1);
        tick(); tick(); tick(); tick(); tick();
        check("f2_underflow_sticky", underflow, 1);
        check("f2_valid", pixel_valid, 1);
        check("f2_head", pixel_out, 4'h3);
        check("f2_occ", dut.w_occ, 2);
        check("f2_inflight", dut.r_in_flight, 2);

        // frame_start with two requests outstanding: late samples must be dropped.
        record_frame(rm, sm, vm, uf0, occ0);
        check("f3_underflow_clr", uf0, 0);
        check("f3_occ_flushed", occ0, 0);
        check("f3_reset_mask", rm, 16'h000F);
        check("f3_strobe_mask", sm, 16'h0550);
        check("f3_valid_mask", vm, 16'hFF80);
        check("f3_head", pixel_out, 4'h3);

        // Free one slot, catch the strobe, then assert rst between edges.
        pixel_pop = 1'b1;
        tick();
        pixel_pop = 1'b0;
        w = 0;
        while (!frame_next_pixel_out && w < 12) begin
            tick();
            w++;
        end
        check("arst_strobe_seen", frame_next_pixel_out, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_strobe", frame_next_pixel_out, 0);
        check("arst_valid", pixel_valid, 0);
        check("arst_pixel_out", pixel_out, 0);
        tick();
        tick();
        rst = 1'b0;
        cnt_stb = 0; cnt_vld = 0; cnt_rst = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt_stb += int'(frame_next_pixel_out);
            cnt_vld += int'(pixel_valid);
            cnt_rst += int'(frame_reset_out);
        end
        check("post_arst_strobes", cnt_stb, 0);
        check("post_arst_valid", cnt_vld, 0);
        check("post_arst_reset_out", cnt_rst, 0);

        record_frame(rm, sm, vm, uf0, occ0);
        check("f4_reset_mask", rm, 16'h000F);
        check("f4_strobe_mask", sm, 16'h0550);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
